// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver.
//   - internal baud-tick generator (DIVISOR clocks per tick, OVERSAMPLE ticks per bit)
//   - 2-FF input synchroniser plus falling-edge detector on the serial line
//   - start-bit centre re-check for false-start rejection
//   - configurable data width, stop length, framing-error flag
//   - optional parity check, compiled in when the macro UART_PARITY_EN is defined;
//     without it o_parity_err is tied low and PARITY_ODD is ignored.
module uart_rx_os #(
    parameter int DIVISOR    = 163,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int SB_TICKS   = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    // ------------------------------------------------------------------
    // Derived widths and compare constants
    // ------------------------------------------------------------------
    localparam int S_MAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
    localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int C_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    localparam logic [C_W-1:0] CNT_LAST     = C_W'(DIVISOR - 1);
    localparam logic [S_W-1:0] S_START_LAST = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_BIT_LAST   = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_LAST  = S_W'(SB_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST       = N_W'(DATA_BITS - 1);

    // FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] ST_PARITY     = 3'd3;
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic                 rx_meta_reg;
    logic                 rx_s_reg;
    logic                 rx_prev_reg;
    logic                 start_edge;

    logic [C_W-1:0]       cnt_reg;
    logic                 tick;

    logic [2:0]           state_reg,  state_next;
    logic [S_W-1:0]       s_reg,      s_next;
    logic [N_W-1:0]       n_reg,      n_next;
    logic [DATA_BITS-1:0] shift_reg,  shift_next;

    logic [DATA_BITS-1:0] data_reg,   data_next;
    logic                 done_reg,   done_next;
    logic                 ferr_reg,   ferr_next;

`ifdef UART_PARITY_EN
    logic                 par_err_reg, par_err_next;
    logic                 perr_reg,    perr_next;
`else
    logic                 unused_parity_sense;
    assign unused_parity_sense = PARITY_ODD[0];
`endif

    // ------------------------------------------------------------------
    // Input synchroniser: both stages idle high so reset never looks like a start bit
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= i_rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // Previous synchronised level, used to detect a true high-to-low edge.
    // A line held low after a break produces no edge, so START is not re-entered
    // until the line has gone high again.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_prev_reg <= 1'b1;
        end else begin
            rx_prev_reg <= rx_s_reg;
        end
    end

    assign start_edge = (state_reg == ST_IDLE) && rx_prev_reg && !rx_s_reg;

    // ------------------------------------------------------------------
    // Oversample tick generator, re-phased to the detected start edge
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_reg <= '0;
        end else if (start_edge || (cnt_reg == CNT_LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == CNT_LAST);

    // ------------------------------------------------------------------
    // Receive FSM: next-state and datapath decisions
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        done_next  = 1'b0;
        ferr_next  = ferr_reg;
`ifdef UART_PARITY_EN
        par_err_next = par_err_reg;
        perr_next    = perr_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (start_edge) begin
                    state_next = ST_START;
                    s_next     = '0;
                end
            end

            // Re-check the line at the middle of the start bit; a glitch that
            // has already gone high is dropped silently.
            ST_START: begin
                if (tick) begin
                    if (s_reg == S_START_LAST) begin
                        s_next = '0;
                        if (!rx_s_reg) begin
                            state_next = ST_DATA;
                            n_next     = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end

            // Sample each data bit at its centre, LSB first, shifting right.
            ST_DATA: begin
                if (tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next     = '0;
                        shift_next = {rx_s_reg, shift_reg[DATA_BITS-1:1]};
                        if (n_reg == N_LAST) begin
                            n_next     = '0;
                            state_next = ST_AFTER_DATA;
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end

`ifdef UART_PARITY_EN
            // Parity over data plus parity bit must equal the selected sense.
            ST_PARITY: begin
                if (tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next       = '0;
                        par_err_next = ((^shift_reg) ^ rx_s_reg) != PARITY_ODD[0];
                        state_next   = ST_STOP;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`endif

            // Sample the stop bit and publish the frame; errored frames are
            // still delivered with their flags.
            ST_STOP: begin
                if (tick) begin
                    if (s_reg == S_STOP_LAST) begin
                        s_next     = '0;
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                        data_next  = shift_reg;
                        ferr_next  = ~rx_s_reg;
`ifdef UART_PARITY_EN
                        perr_next  = par_err_reg;
`endif
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                s_next     = '0;
                n_next     = '0;
            end
        endcase
    end

    // FSM state, counters and shift register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            shift_reg <= shift_next;
        end
    end

    // Output registers: word, done strobe and framing flag held until next frame
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_reg <= '0;
            done_reg <= 1'b0;
            ferr_reg <= 1'b0;
        end else begin
            data_reg <= data_next;
            done_reg <= done_next;
            ferr_reg <= ferr_next;
        end
    end

`ifdef UART_PARITY_EN
    // Parity result of the current frame and the published parity flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            par_err_reg <= 1'b0;
            perr_reg    <= 1'b0;
        end else begin
            par_err_reg <= par_err_next;
            perr_reg    <= perr_next;
        end
    end

    assign o_parity_err = perr_reg;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_data      = data_reg;
    assign o_rx_done   = done_reg;
    assign o_frame_err = ferr_reg;
    // Busy stays up through the done cycle so it falls one cycle after the strobe.
    assign o_busy      = (state_reg != ST_IDLE) || done_reg;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed + randomized bench for uart_rx_os.
// A frame-level model predicts (data, frame error, parity error) for every
// frame the bench transmits; a monitor collects what the receiver reports.
module tb_uart_rx_os;

`ifdef UART_PARITY_EN
    localparam int DB  = 7;
    localparam bit PAR = 1'b1;
`else
    localparam int DB  = 8;
    localparam bit PAR = 1'b0;
`endif
    localparam int PODD   = 0;
    localparam int BIT_T  = 52083;   // bit period, clock period is 20
    localparam logic [8:0] DMASK = 9'((1 << DB) - 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [DB-1:0] data;
    logic          rx_done;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    // model: expected frames
    logic [8:0] exp_d[$];
    logic       exp_f[$];
    logic       exp_p[$];
    // monitor: observed frames
    logic [8:0] obs_d[$];
    logic       obs_f[$];
    logic       obs_p[$];
    logic [8:0] last_data;

    uart_rx_os #(
        .DIVISOR   (163),
        .OVERSAMPLE(16),
        .DATA_BITS (DB),
        .SB_TICKS  (16),
        .PARITY_ODD(PODD)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx        (rx),
        .o_data      (data),
        .o_rx_done   (rx_done),
        .o_frame_err (frame_err),
        .o_parity_err(parity_err),
        .o_busy      (busy)
    );

    always #10 clk = ~clk;

    // capture every done strobe away from the active edge
    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            obs_d.push_back(9'(data));
            obs_f.push_back(frame_err);
            obs_p.push_back(parity_err);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // transmit one frame and record the model's prediction for it
    task automatic send_frame(input logic [8:0] d, input bit stop_val, input bit pbit);
        logic [8:0] dm;
        logic       pe;
        dm = d & DMASK;
        pe = PAR ? (((^dm) ^ pbit) != PODD[0]) : 1'b0;
        $display("tx frame: data=0x%0h stop=%0b parity_bit=%0b -> expect ferr=%0b perr=%0b",
                 dm, stop_val, pbit, !stop_val, pe);
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < DB; i++) begin
            rx = dm[i];
            #(BIT_T);
        end
        if (PAR) begin
            rx = pbit;
            #(BIT_T);
        end
        rx = stop_val;
        #(BIT_T);
        rx = 1'b1;
        exp_d.push_back(dm);
        exp_f.push_back(!stop_val);
        exp_p.push_back(pe);
    endtask

    // compare everything the receiver reported against the model
    task automatic verify(input string tag);
        logic [8:0] ed, od;
        logic       ef, ep, of, op;
        chk({tag, " done_count"}, obs_d.size(), exp_d.size());
        while (exp_d.size() > 0) begin
            ed = exp_d.pop_front();
            ef = exp_f.pop_front();
            ep = exp_p.pop_front();
            last_data = ed;
            if (obs_d.size() > 0) begin
                od = obs_d.pop_front();
                of = obs_f.pop_front();
                op = obs_p.pop_front();
                $display("rx frame [%s]: data=0x%0h ferr=%0b perr=%0b", tag, od, of, op);
                chk({tag, " data"}, od, ed);
                chk({tag, " frame_err"}, of, ef);
                chk({tag, " parity_err"}, op, ep);
            end
        end
        obs_d.delete();
        obs_f.delete();
        obs_p.delete();
        chk({tag, " busy_after"}, busy, 1'b0);
    endtask

    initial begin
        logic [8:0] rd;
        bit         rs;
        bit         rp;

        rst = 1'b1;
        rx  = 1'b1;
        last_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset data", data, 0);
        chk("reset done", rx_done, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset parity_err", parity_err, 0);
        chk("reset busy", busy, 0);
        #(BIT_T);

        // single clean frame
        send_frame(9'h020, 1'b1, 1'b1);
        verify("single_0x20");

        // three frames with no idle gap
        send_frame(9'h020, 1'b1, 1'b1);
        send_frame(9'h002, 1'b1, 1'b1);
        send_frame(9'h002, 1'b1, 1'b1);
        verify("b2b");

        // false start: 3 time-units-thousand low pulse
        rx = 1'b0;
        #2000;
        chk("false_start busy_high", busy, 1'b1);
        #1000;
        rx = 1'b1;
        #(BIT_T);
        $display("false start pulse applied");
        chk("false_start no_done", obs_d.size(), 0);
        chk("false_start busy_low", busy, 1'b0);
        chk("false_start data_held", data, last_data[DB-1:0]);

        // stop bit forced low, then a clean frame clears the flag
        send_frame(9'h0A5, 1'b0, 1'b0);
        #(BIT_T);
        verify("bad_stop_0xA5");
        chk("bad_stop flag_held", frame_err, 1'b1);
        send_frame(9'h03C, 1'b1, 1'b0);
        verify("clean_0x3C");

        // reset in the middle of data bit 4 of 0xFF
        rx = 1'b0;
        #(BIT_T);
        rx = 1'b1;
        #(BIT_T * 4 + BIT_T / 2);
        chk("midframe busy", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("reset pulsed mid-frame");
        chk("midreset data", data, 0);
        chk("midreset frame_err", frame_err, 0);
        chk("midreset parity_err", parity_err, 0);
        chk("midreset busy", busy, 0);
        chk("midreset done", rx_done, 0);
        #(BIT_T * 6);
        chk("midreset no_done", obs_d.size(), 0);
        send_frame(9'h055, 1'b1, 1'b0);
        verify("after_reset_0x55");

`ifdef UART_PARITY_EN
        send_frame(9'h041, 1'b1, 1'b0);
        verify("parity_ok_0x41");
        send_frame(9'h041, 1'b1, 1'b1);
        verify("parity_bad_0x41");
`endif

        // randomized frames
        for (int k = 0; k < 5; k++) begin
            rd = 9'($urandom_range(0, 511));
            rs = ($urandom_range(0, 3) != 0);
            rp = 1'($urandom_range(0, 1));
            send_frame(rd, rs, rp);
            if (!rs) #(BIT_T);
        end
        verify("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
